escalonador_round_robin: RTL and testbench



---
 rtl/escalonador_round_robin.sv | 190 +++++++++++++++++++
 tb/tb_escalonador_round_robin.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler placed in front of the CPU PC mux: keeps a saved
// PC and state per process, counts the quantum in retired instructions and
// pulses switch_req with the PC the CPU must load.
module escalonador_round_robin #(
  parameter int MAX_PROC = 4,
  parameter int QUANTUM  = 8,
  parameter int PC_W     = 32,
  parameter int ID_W     = $clog2(MAX_PROC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            proc_load,
  input  logic [ID_W-1:0] proc_load_id,
  input  logic [PC_W-1:0] proc_load_pc,
  input  logic            proc_start,
  input  logic            instr_retire,
  input  logic [PC_W-1:0] pc_atual,
  input  logic            proc_end,
  input  logic            io_block,
  input  logic            io_done,
  input  logic [ID_W-1:0] io_done_id,
  output logic            switch_req,
  output logic [PC_W-1:0] switch_pc,
  output logic [ID_W-1:0] proc_atual,
  output logic            proc_valid,
  output logic            all_done,
  output logic [7:0]      quantum_left
);

  localparam logic [1:0] E_EMPTY    = 2'd0;
  localparam logic [1:0] E_READY    = 2'd1;
  localparam logic [1:0] E_BLOCKED  = 2'd2;
  localparam logic [1:0] E_FINISHED = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SELECT   = 3'd1;
  localparam logic [2:0] S_DISPATCH = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_SAVE     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [7:0] Q_LOAD = 8'(QUANTUM);

  logic [2:0]          state_reg;
  logic                first_sel_reg;
  logic [MAX_PROC-1:0] ready_vec;
  logic [MAX_PROC-1:0] blocked_vec;
  logic [PC_W-1:0]     entry_pc [MAX_PROC];

  logic run_end;
  logic run_block;

  // proc_end outranks io_block; both outrank quantum expiry
  assign run_end   = (state_reg == S_RUN) && proc_end;
  assign run_block = (state_reg == S_RUN) && io_block && !proc_end;

  // Process table: one state/PC pair per entry
  for (genvar gi = 0; gi < MAX_PROC; gi++) begin : g_entry
    localparam logic [ID_W-1:0] ENTRY_ID = ID_W'(gi);

    logic [1:0]      st_reg;
    logic [PC_W-1:0] pc_reg;
    logic            load_hit;
    logic            end_hit;
    logic            block_hit;
    logic            save_hit;
    logic            wake_hit;

    assign load_hit  = (state_reg == S_IDLE) && proc_load && (proc_load_id == ENTRY_ID);
    assign end_hit   = run_end && (proc_atual == ENTRY_ID);
    assign block_hit = run_block && (proc_atual == ENTRY_ID);
    assign save_hit  = (state_reg == S_SAVE) && (proc_atual == ENTRY_ID);
    // A wake-up arriving together with the block of the same entry still wins
    assign wake_hit  = io_done && (state_reg != S_IDLE) && (io_done_id == ENTRY_ID) &&
                       ((st_reg == E_BLOCKED) || block_hit);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st_reg <= E_EMPTY;
        pc_reg <= '0;
      end else begin
        if (load_hit) begin
          st_reg <= E_READY;
          pc_reg <= proc_load_pc;
        end
        if (end_hit) begin
          st_reg <= E_FINISHED;
        end
        if (block_hit) begin
          st_reg <= E_BLOCKED;
          pc_reg <= pc_atual + PC_W'(1);
        end
        if (save_hit) begin
          st_reg <= E_READY;
          pc_reg <= pc_atual;
        end
        if (wake_hit) begin
          st_reg <= E_READY;
        end
      end
    end

    assign ready_vec[gi]   = (st_reg == E_READY);
    assign blocked_vec[gi] = (st_reg == E_BLOCKED);
    assign entry_pc[gi]    = pc_reg;
  end

  // Round-robin search: proc_atual+1 first, proc_atual itself last
  logic [ID_W-1:0] base_id;
  logic [ID_W-1:0] cand_id;
  logic [ID_W-1:0] pick_id;
  logic            pick_found;

  always_comb begin
    base_id    = first_sel_reg ? '0 : proc_atual + ID_W'(1);
    cand_id    = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int k = MAX_PROC - 1; k >= 0; k--) begin
      cand_id = base_id + ID_W'(k);
      if (ready_vec[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      first_sel_reg <= 1'b0;
      switch_req    <= 1'b0;
      switch_pc     <= '0;
      proc_atual    <= '0;
      proc_valid    <= 1'b0;
      all_done      <= 1'b0;
      quantum_left  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (proc_start) begin
            state_reg     <= S_SELECT;
            first_sel_reg <= 1'b1;
          end
        end
        S_SELECT: begin
          if (pick_found) begin
            state_reg     <= S_DISPATCH;
            first_sel_reg <= 1'b0;
            switch_req    <= 1'b1;
            switch_pc     <= entry_pc[pick_id];
            proc_atual    <= pick_id;
            proc_valid    <= 1'b1;
            quantum_left  <= Q_LOAD;
          end else if (blocked_vec == '0) begin
            state_reg <= S_DONE;
            all_done  <= 1'b1;
          end
        end
        S_DISPATCH: begin
          state_reg  <= S_RUN;
          switch_req <= 1'b0;
          switch_pc  <= '0;
        end
        S_RUN: begin
          if (proc_end || io_block) begin
            state_reg  <= S_SELECT;
            proc_valid <= 1'b0;
          end else if (instr_retire) begin
            quantum_left <= quantum_left - 8'd1;
            if (quantum_left == 8'd1) begin
              state_reg <= S_SAVE;
            end
          end
        end
        S_SAVE: begin
          state_reg  <= S_SELECT;
          proc_valid <= 1'b0;
        end
        S_DONE: begin
          state_reg <= S_DONE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_round_robin.sv
// Bench for escalonador_round_robin: directed scenarios plus a randomized run
// compared against a process-table model of the round-robin rules.
module tb_escalonador_round_robin;

  localparam int MAX_PROC = 4;
  localparam int QUANTUM  = 8;
  localparam int PC_W     = 32;
  localparam int ID_W     = 2;

  localparam int M_EMPTY = 0, M_READY = 1, M_BLOCKED = 2, M_FINISHED = 3;
  localparam int EV_NONE = 0, EV_END = 1, EV_BLOCK = 2, EV_EXP = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            proc_load = 1'b0;
  logic [ID_W-1:0] proc_load_id = '0;
  logic [PC_W-1:0] proc_load_pc = '0;
  logic            proc_start = 1'b0;
  logic            instr_retire = 1'b0;
  logic [PC_W-1:0] pc_atual = '0;
  logic            proc_end = 1'b0;
  logic            io_block = 1'b0;
  logic            io_done = 1'b0;
  logic [ID_W-1:0] io_done_id = '0;
  logic            switch_req;
  logic [PC_W-1:0] switch_pc;
  logic [ID_W-1:0] proc_atual;
  logic            proc_valid;
  logic            all_done;
  logic [7:0]      quantum_left;

  int n_checks = 0;
  int n_pass   = 0;

  int          m_st [MAX_PROC];
  logic [31:0] m_pc [MAX_PROC];
  int          m_cur;
  bit          m_first;

  escalonador_round_robin #(
    .MAX_PROC(MAX_PROC), .QUANTUM(QUANTUM), .PC_W(PC_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset),
    .proc_load(proc_load), .proc_load_id(proc_load_id), .proc_load_pc(proc_load_pc),
    .proc_start(proc_start), .instr_retire(instr_retire), .pc_atual(pc_atual),
    .proc_end(proc_end), .io_block(io_block), .io_done(io_done), .io_done_id(io_done_id),
    .switch_req(switch_req), .switch_pc(switch_pc), .proc_atual(proc_atual),
    .proc_valid(proc_valid), .all_done(all_done), .quantum_left(quantum_left)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    proc_load    = 1'b0;
    proc_start   = 1'b0;
    instr_retire = 1'b0;
    proc_end     = 1'b0;
    io_block     = 1'b0;
    io_done      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_pulses();
    pc_atual = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic load(input int id, input logic [31:0] pc);
    proc_load    = 1'b1;
    proc_load_id = ID_W'(id);
    proc_load_pc = pc;
    step();
    proc_load = 1'b0;
  endtask

  // Called in the reference cycle; the dispatch must appear exactly lat cycles later
  task automatic wait_dispatch(input string tag, input int lat, input logic [31:0] exp_pc,
                               input int exp_id);
    for (int k = 1; k < lat; k++) begin
      step();
      clear_pulses();
      n_checks++;
      if (switch_req !== 1'b0)
        $display("FAIL %s early_switch at +%0d: got %0b expected 0", tag, k, switch_req);
      else n_pass++;
    end
    step();
    clear_pulses();
    n_checks++;
    if (switch_req !== 1'b1 || switch_pc !== exp_pc)
      $display("FAIL %s switch: got req=%0b pc=%0d expected req=1 pc=%0d",
               tag, switch_req, switch_pc, exp_pc);
    else n_pass++;
    n_checks++;
    if (proc_atual !== ID_W'(exp_id) || proc_valid !== 1'b1 || quantum_left !== 8'(QUANTUM))
      $display("FAIL %s dispatch_state: got id=%0d valid=%0b q=%0d expected id=%0d valid=1 q=%0d",
               tag, proc_atual, proc_valid, quantum_left, exp_id, QUANTUM);
    else n_pass++;
    $display("dispatch %s: id=%0d pc=%0d", tag, proc_atual, switch_pc);
  endtask

  // From a DISPATCH cycle, retire a whole quantum (with one halted cycle) at PC pc
  task automatic run_slice(input string tag, input logic [31:0] pc);
    step();
    clear_pulses();
    for (int i = 0; i < QUANTUM; i++) begin
      if (i == 3) begin
        instr_retire = 1'b0;
        step();
        n_checks++;
        if (quantum_left !== 8'(QUANTUM - 3))
          $display("FAIL %s quantum_hold: got %0d expected %0d", tag, quantum_left, QUANTUM - 3);
        else n_pass++;
      end
      if (i == QUANTUM - 1) begin
        n_checks++;
        if (quantum_left !== 8'd1)
          $display("FAIL %s quantum_last: got %0d expected 1", tag, quantum_left);
        else n_pass++;
      end
      instr_retire = 1'b1;
      pc_atual     = pc;
      if (i < QUANTUM - 1) step();
    end
  endtask

  function automatic int m_select();
    int id;
    for (int k = 0; k < MAX_PROC; k++) begin
      id = m_first ? k : (m_cur + 1 + k) % MAX_PROC;
      if (m_st[id] == M_READY) return id;
    end
    return -1;
  endfunction

  function automatic int m_count(input int st);
    int n = 0;
    for (int i = 0; i < MAX_PROC; i++) if (m_st[i] == st) n++;
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (switch_req !== 1'b0 || switch_pc !== '0)
      $display("FAIL reset_switch: got req=%0b pc=%0d expected 0/0", switch_req, switch_pc);
    else n_pass++;
    n_checks++;
    if (proc_atual !== '0 || proc_valid !== 1'b0)
      $display("FAIL reset_proc: got id=%0d valid=%0b expected 0/0", proc_atual, proc_valid);
    else n_pass++;
    n_checks++;
    if (all_done !== 1'b0 || quantum_left !== 8'd0)
      $display("FAIL reset_misc: got all_done=%0b q=%0d expected 0/0", all_done, quantum_left);
    else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset();
    load(0, 300);
    load(1, 600);
    load(2, 900);
    proc_start = 1'b1;
    wait_dispatch("start_p0", 2, 300, 0);
    run_slice("p0", 308);
    wait_dispatch("p0_to_p1", 3, 600, 1);
    run_slice("p1", 650);
    wait_dispatch("p1_to_p2", 3, 900, 2);
    run_slice("p2", 950);
    wait_dispatch("p2_to_p0", 3, 308, 0);
  endtask

  task automatic test_io_block();
    do_reset();
    load(0, 300);
    load(1, 600);
    load(2, 900);
    proc_start = 1'b1;
    wait_dispatch("io_start", 2, 300, 0);
    run_slice("io_p0", 308);
    wait_dispatch("io_p0_to_p1", 3, 600, 1);
    step();
    instr_retire = 1'b1;
    step();
    instr_retire = 1'b0;
    io_block     = 1'b1;
    pc_atual     = 609;
    wait_dispatch("io_block_p1", 2, 900, 2);
    io_done    = 1'b1;
    io_done_id = 2'd1;
    run_slice("io_p2", 950);
    wait_dispatch("io_p2_to_p0", 3, 308, 0);
    run_slice("io_p0b", 330);
    wait_dispatch("io_resume_p1", 3, 610, 1);
  endtask

  task automatic test_single();
    do_reset();
    load(0, 300);
    proc_start = 1'b1;
    wait_dispatch("single_start", 2, 300, 0);
    proc_load    = 1'b1;
    proc_load_id = 2'd1;
    proc_load_pc = 999;
    run_slice("single", 320);
    wait_dispatch("single_again", 3, 320, 0);
  endtask

  task automatic test_end();
    do_reset();
    load(0, 100);
    load(1, 200);
    proc_start = 1'b1;
    wait_dispatch("end_start", 2, 100, 0);
    step();
    for (int i = 0; i < QUANTUM - 1; i++) begin
      instr_retire = 1'b1;
      step();
    end
    instr_retire = 1'b1;
    proc_end     = 1'b1;
    pc_atual     = 777;
    wait_dispatch("end_p0_to_p1", 2, 200, 1);
    run_slice("end_p1", 250);
    wait_dispatch("end_p1_only", 3, 250, 1);
    step();
    proc_end = 1'b1;
    step();
    clear_pulses();
    n_checks++;
    if (switch_req !== 1'b0 || proc_valid !== 1'b0)
      $display("FAIL end_select: got req=%0b valid=%0b expected 0/0", switch_req, proc_valid);
    else n_pass++;
    step();
    n_checks++;
    if (all_done !== 1'b1 || proc_valid !== 1'b0 || switch_req !== 1'b0)
      $display("FAIL end_all_done: got done=%0b valid=%0b req=%0b expected 1/0/0",
               all_done, proc_valid, switch_req);
    else n_pass++;
    step();
    step();
    step();
    n_checks++;
    if (all_done !== 1'b1)
      $display("FAIL end_done_hold: got %0b expected 1", all_done);
    else n_pass++;
  endtask

  task automatic test_blocked_reset();
    do_reset();
    load(0, 10);
    load(1, 20);
    proc_start = 1'b1;
    wait_dispatch("blk_start", 2, 10, 0);
    step();
    io_block = 1'b1;
    pc_atual = 15;
    wait_dispatch("blk_p0", 2, 20, 1);
    step();
    io_block = 1'b1;
    pc_atual = 25;
    for (int k = 0; k < 4; k++) begin
      step();
      clear_pulses();
      n_checks++;
      if (switch_req !== 1'b0 || proc_valid !== 1'b0)
        $display("FAIL blk_wait %0d: got req=%0b valid=%0b expected 0/0", k, switch_req, proc_valid);
      else n_pass++;
    end
    io_done    = 1'b1;
    io_done_id = 2'd0;
    wait_dispatch("blk_wake_p0", 2, 16, 0);
    step();
    instr_retire = 1'b1;
    step();
    reset = 1'b1;
    #2;
    n_checks++;
    if (switch_req !== 1'b0 || switch_pc !== '0 || proc_valid !== 1'b0)
      $display("FAIL async_reset_a: got req=%0b pc=%0d valid=%0b expected 0/0/0",
               switch_req, switch_pc, proc_valid);
    else n_pass++;
    n_checks++;
    if (proc_atual !== '0 || quantum_left !== 8'd0 || all_done !== 1'b0)
      $display("FAIL async_reset_b: got id=%0d q=%0d done=%0b expected 0/0/0",
               proc_atual, quantum_left, all_done);
    else n_pass++;
    step();
    reset = 1'b0;
    clear_pulses();
    proc_start = 1'b1;
    step();
    clear_pulses();
    step();
    n_checks++;
    if (all_done !== 1'b1 || switch_req !== 1'b0 || proc_valid !== 1'b0)
      $display("FAIL empty_done: got done=%0b req=%0b valid=%0b expected 1/0/0",
               all_done, switch_req, proc_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    int lat, ev, e, q, r, bid, cyc;
    logic [31:0] pc_drv;
    do_reset();
    for (int i = 0; i < MAX_PROC; i++) begin
      m_st[i] = M_EMPTY;
      m_pc[i] = '0;
      if (i == 0 || $urandom_range(0, 9) < 7) begin
        pc_drv = 32'($urandom_range(0, 65535));
        load(i, pc_drv);
        m_st[i] = M_READY;
        m_pc[i] = pc_drv;
      end
    end
    m_cur      = 0;
    m_first    = 1'b1;
    proc_start = 1'b1;
    lat        = 2;
    ev         = EV_NONE;
    for (int nd = 0; nd < 40; nd++) begin
      for (int k = 1; k < lat; k++) begin
        step();
        clear_pulses();
        n_checks++;
        if (switch_req !== 1'b0)
          $display("FAIL rnd_early_switch %0d: got %0b expected 0", nd, switch_req);
        else n_pass++;
        instr_retire = 1'($urandom_range(0, 1));
        pc_atual     = $urandom;
        if (k == 1 && ev == EV_EXP) m_pc[m_cur] = pc_atual;
      end
      step();
      clear_pulses();
      e = m_select();
      if (e < 0) e = m_cur;
      n_checks++;
      if (switch_req !== 1'b1 || switch_pc !== m_pc[e] || proc_atual !== ID_W'(e))
        $display("FAIL rnd_dispatch %0d: got req=%0b id=%0d pc=%0d expected req=1 id=%0d pc=%0d",
                 nd, switch_req, proc_atual, switch_pc, e, m_pc[e]);
      else n_pass++;
      $display("dispatch rnd%0d: id=%0d pc=%0d", nd, proc_atual, switch_pc);
      m_cur        = e;
      m_first      = 1'b0;
      instr_retire = 1'($urandom_range(0, 1));
      q            = QUANTUM;
      ev           = EV_NONE;
      for (cyc = 0; cyc < 200 && ev == EV_NONE; cyc++) begin
        step();
        clear_pulses();
        n_checks++;
        if (quantum_left !== 8'(q) || proc_valid !== 1'b1 || switch_req !== 1'b0)
          $display("FAIL rnd_run %0d: got q=%0d valid=%0b req=%0b expected q=%0d valid=1 req=0",
                   nd, quantum_left, proc_valid, switch_req, q);
        else n_pass++;
        pc_atual     = $urandom;
        instr_retire = ($urandom_range(0, 2) != 0);
        proc_end     = ($urandom_range(0, 39) == 0);
        io_block     = ($urandom_range(0, 19) == 0);
        io_done      = ($urandom_range(0, 5) == 0);
        io_done_id   = ID_W'($urandom_range(0, MAX_PROC - 1));
        if (proc_end) begin
          m_st[m_cur] = M_FINISHED;
          ev = EV_END;
        end else if (io_block) begin
          m_pc[m_cur] = pc_atual + 32'd1;
          m_st[m_cur] = M_BLOCKED;
          ev = EV_BLOCK;
        end else if (instr_retire) begin
          q--;
          if (q == 0) ev = EV_EXP;
        end
        if (io_done && m_st[io_done_id] == M_BLOCKED) m_st[io_done_id] = M_READY;
      end
      if (ev == EV_NONE) begin
        n_checks++;
        $display("FAIL rnd_timeout %0d: got no event in 200 cycles expected an event", nd);
        break;
      end
      if (ev == EV_EXP) begin
        lat = 3;
      end else if (m_count(M_READY) > 0) begin
        lat = 2;
      end else if (m_count(M_BLOCKED) > 0) begin
        r = $urandom_range(1, 4);
        for (int k = 0; k < r; k++) begin
          step();
          clear_pulses();
          n_checks++;
          if (switch_req !== 1'b0 || proc_valid !== 1'b0)
            $display("FAIL rnd_wait %0d: got req=%0b valid=%0b expected 0/0",
                     nd, switch_req, proc_valid);
          else n_pass++;
        end
        bid = -1;
        while (bid < 0) begin
          r = $urandom_range(0, MAX_PROC - 1);
          if (m_st[r] == M_BLOCKED) bid = r;
        end
        io_done    = 1'b1;
        io_done_id = ID_W'(bid);
        m_st[bid]  = M_READY;
        lat        = 2;
        ev         = EV_NONE;
      end else begin
        step();
        clear_pulses();
        step();
        n_checks++;
        if (all_done !== 1'b1 || proc_valid !== 1'b0 || switch_req !== 1'b0)
          $display("FAIL rnd_done: got done=%0b valid=%0b req=%0b expected 1/0/0",
                   all_done, proc_valid, switch_req);
        else n_pass++;
        break;
      end
    end
    clear_pulses();
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_io_block();
    test_single();
    test_end();
    test_blocked_reset();
    for (int run = 0; run < 4; run++) test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
